order_arbiter: RTL and testbench



---
 rtl/order_arbiter.sv | 164 ++++++++++++++++
 tb/tb_order_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/order_arbiter.sv
// Round-robin order arbiter in front of the matching engine: grants one source at a time,
// strobes the order into the engine, then holds for a fixed window while collecting the match flag.
module order_arbiter #(
    parameter int N_REQ       = 3,
    parameter int PRICE_W     = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           req_side,
    input  logic [N_REQ*PRICE_W-1:0]   req_price,
    input  logic                       halt,
    input  logic                       eng_match,
    output logic [N_REQ-1:0]           grant,
    output logic                       eng_valid,
    output logic                       eng_side,
    output logic [PRICE_W-1:0]         eng_price,
    output logic                       busy,
    output logic                       done,
    output logic                       match_seen,
    output logic [1:0]                 last_src,
    output logic [7:0]                 order_count
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 flag_q, flag_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic                 side_q, side_d;
    logic [PRICE_W-1:0]   price_q, price_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 ms_q, ms_d;
    logic [1:0]           last_q, last_d;
    logic [7:0]           count_q, count_d;

    logic                 win_found;
    logic [IW-1:0]        win_idx;
    logic [IW:0]          scan;

    // Scan ptr+1, ptr+2, ... so the most recently served source is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan = {1'b0, ptr_q} + (IW+1)'(k);
            if (scan >= (IW+1)'(N_REQ)) begin
                scan = scan - (IW+1)'(N_REQ);
            end
            if (!win_found && req[scan[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        grant_d = '0;
        valid_d = 1'b0;
        side_d  = side_q;
        price_d = price_q;
        done_d  = 1'b0;
        ms_d    = 1'b0;
        last_d  = last_q;
        count_d = count_q;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (win_found) begin
                    grant_d[win_idx] = 1'b1;
                    valid_d = 1'b1;
                    side_d  = req_side[win_idx];
                    price_d = req_price[win_idx*PRICE_W +: PRICE_W];
                    ptr_d   = win_idx;
                    last_d  = 2'(win_idx);
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The flag restarts here and already includes the engine's answer in the strobe cycle.
                cnt_d   = '0;
                flag_d  = eng_match;
                state_d = WAIT;
            end
            WAIT: begin
                flag_d = flag_q | eng_match;
                if (cnt_q == CW'(WAIT_CYCLES-1)) begin
                    done_d  = 1'b1;
                    ms_d    = flag_q | eng_match;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N_REQ-1);
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            grant_q <= '0;
            valid_q <= 1'b0;
            side_q  <= 1'b0;
            price_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ms_q    <= 1'b0;
            last_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            side_q  <= side_d;
            price_q <= price_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ms_q    <= ms_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign grant       = grant_q;
    assign eng_valid   = valid_q;
    assign eng_side    = side_q;
    assign eng_price   = price_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign match_seen  = ms_q;
    assign last_src    = last_q;
    assign order_count = count_q;

endmodule

// File: tb/tb_order_arbiter.sv
// Scoreboard bench for order_arbiter: a timeline model predicts grant and done events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_order_arbiter;

    localparam int N  = 3;
    localparam int PW = 8;
    localparam int W  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      req_side = '0;
    logic [N*PW-1:0]   req_price = '0;
    logic              halt = 1'b0;
    logic              eng_match = 1'b0;
    logic [N-1:0]      grant;
    logic              eng_valid;
    logic              eng_side;
    logic [PW-1:0]     eng_price;
    logic              busy;
    logic              done;
    logic              match_seen;
    logic [1:0]        last_src;
    logic [7:0]        order_count;

    order_arbiter #(.N_REQ(N), .PRICE_W(PW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_side(req_side), .req_price(req_price),
        .halt(halt), .eng_match(eng_match), .grant(grant), .eng_valid(eng_valid),
        .eng_side(eng_side), .eng_price(eng_price), .busy(busy), .done(done),
        .match_seen(match_seen), .last_src(last_src), .order_count(order_count)
    );

    always #10 clk = ~clk;

    typedef struct {
        int         edgeAt;
        int         src;
        logic [7:0] price;
        logic       side;
        int         cnt;
    } grantExp_t;

    typedef struct {
        int   edgeAt;
        logic ms;
    } doneExp_t;

    grantExp_t gq[$];
    doneExp_t  dq[$];

    int compared = 0;
    int mismatched = 0;
    int edgeNo = 0;
    int age = 100;

    int mPtr = N-1;
    int freeAt = 1;
    int winStart = 0;
    int winEnd = 0;
    int mCount = 0;
    int mWin = -1;
    int j = 0;
    bit halted = 1'b0;
    bit inWin = 1'b0;
    bit acc = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edgeNo);
        end
    endtask

    // Reference timeline: each accepted order occupies its grant edge, a window of
    // 1+W sampled edges for the match flag, and frees the arbiter W+2 edges later.
    always @(posedge clk) begin
        edgeNo++;
        if (!reset) begin
            mPtr = N-1; freeAt = edgeNo + 1; halted = 1'b0; inWin = 1'b0; mCount = 0;
            gq.delete(); dq.delete();
        end else begin
            if (inWin && edgeNo >= winStart) begin
                acc = acc | eng_match;
                if (edgeNo == winEnd) begin
                    dq.push_back('{edgeNo, acc});
                    inWin = 1'b0;
                end
            end
            if (halted) begin
                if (!halt) begin
                    halted = 1'b0;
                    freeAt = edgeNo + 1;
                end
            end else if (edgeNo >= freeAt) begin
                if (halt) begin
                    halted = 1'b1;
                end else if (req != '0) begin
                    mWin = -1;
                    for (int k = 1; k <= N; k++) begin
                        j = (mPtr + k) % N;
                        if (mWin < 0 && req[j[1:0]]) mWin = j;
                    end
                    mPtr = mWin;
                    mCount = (mCount < 255) ? mCount + 1 : 255;
                    gq.push_back('{edgeNo, mWin, req_price[mWin*PW +: PW], req_side[mWin], mCount});
                    inWin = 1'b1; acc = 1'b0;
                    winStart = edgeNo + 1; winEnd = edgeNo + 1 + W; freeAt = edgeNo + 2 + W;
                end
            end
        end
    end

    // Monitor: compares DUT events against the queued expectations.
    always @(negedge clk) begin
        grantExp_t g;
        doneExp_t  d;
        if (gq.size() > 0 && gq[0].edgeAt < edgeNo) begin
            g = gq.pop_front();
            checkOutput("grant_missing", 32'(grant), 32'(1 << g.src));
        end
        if (dq.size() > 0 && dq[0].edgeAt < edgeNo) begin
            d = dq.pop_front();
            checkOutput("done_missing", 32'(done), 32'd1);
        end
        if (grant != '0 || eng_valid) begin
            if (gq.size() == 0) begin
                checkOutput("grant_unexpected", 32'(grant), 32'd0);
            end else begin
                g = gq.pop_front();
                checkOutput("grant_edge", 32'(edgeNo), 32'(g.edgeAt));
                checkOutput("grant_onehot", 32'(grant), 32'(1 << g.src));
                checkOutput("eng_valid", 32'(eng_valid), 32'd1);
                checkOutput("eng_price", 32'(eng_price), 32'(g.price));
                checkOutput("eng_side", 32'(eng_side), 32'(g.side));
                checkOutput("last_src", 32'(last_src), 32'(g.src));
                checkOutput("order_count", 32'(order_count), 32'(g.cnt));
                checkOutput("busy_issue", 32'(busy), 32'd1);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                checkOutput("done_unexpected", 32'(done), 32'd0);
            end else begin
                d = dq.pop_front();
                checkOutput("done_edge", 32'(edgeNo), 32'(d.edgeAt));
                checkOutput("match_seen", 32'(match_seen), 32'(d.ms));
                checkOutput("busy_done", 32'(busy), 32'd0);
            end
        end
    end

    // One cycle of requester/halt/engine behaviour, driven at the negedge.
    task automatic applyStimulus(input int reqP, input int haltP, input int matchP, input bit directedMatch);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(99) < reqP) begin
                req[i] = 1'b1;
                req_price[i*PW +: PW] = 8'($urandom);
                req_side[i] = 1'($urandom);
            end
        end
        if ($urandom_range(99) < haltP) halt = ~halt;
        if (eng_valid) age = 0;
        else if (age < 100) age++;
        eng_match = directedMatch ? (age == 2) : ($urandom_range(99) < matchP);
    endtask

    task automatic waitBusy();
        for (int i = 0; i < 30; i++) begin
            applyStimulus(100, 0, 25, 1'b0);
            if (busy && !eng_valid) break;
        end
        checkOutput("wait_busy", 32'(busy && !eng_valid), 32'd1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_grant"}, 32'(grant), 32'd0);
        checkOutput({tag, "_valid"}, 32'(eng_valid), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_ms"}, 32'(match_seen), 32'd0);
        checkOutput({tag, "_last"}, 32'(last_src), 32'd0);
        checkOutput({tag, "_count"}, 32'(order_count), 32'd0);
        checkOutput({tag, "_price"}, 32'(eng_price), 32'd0);
        checkOutput({tag, "_side"}, 32'(eng_side), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkAllZero("reset");

        // Single sell order from source 1 at 0x40.
        reset = 1'b1;
        req[1] = 1'b1; req_price[PW +: PW] = 8'h40; req_side[1] = 1'b1;
        @(negedge clk);
        checkOutput("tp1_grant", 32'(grant), 32'b010);
        checkOutput("tp1_price", 32'(eng_price), 32'h40);
        checkOutput("tp1_side", 32'(eng_side), 32'd1);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("tp1_done", 32'(done), 32'd1);
        checkOutput("tp1_count", 32'(order_count), 32'd1);
        checkOutput("tp1_last", 32'(last_src), 32'd1);

        repeat (40) applyStimulus(100, 0, 25, 1'b0);
        repeat (40) applyStimulus(100, 0, 0, 1'b1);
        repeat (400) applyStimulus(30, 10, 25, 1'b0);
        halt = 1'b0;
        repeat (8) applyStimulus(0, 0, 25, 1'b0);

        // Halt raised mid-window with source 0 pending.
        waitBusy();
        halt = 1'b1;
        if (!req[0]) begin
            req[0] = 1'b1; req_price[PW-1:0] = 8'($urandom); req_side[0] = 1'($urandom);
        end
        repeat (8) applyStimulus(0, 0, 25, 1'b0);
        checkOutput("halt_holds", 32'(busy), 32'd0);
        halt = 1'b0;
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("halt_rel_1", 32'(grant), 32'd0);
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("halt_rel_2", 32'(grant != '0), 32'd1);

        repeat (1300) applyStimulus(100, 0, 25, 1'b0);
        checkOutput("count_sat", 32'(order_count), 32'd255);
        repeat (20) applyStimulus(100, 0, 25, 1'b0);

        // Reset during the result window abandons the order.
        waitBusy();
        reset = 1'b0;
        eng_match = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            req[i] = 1'b1; req_price[i*PW +: PW] = 8'($urandom); req_side[i] = 1'($urandom);
        end
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("post_reset_src0", 32'(grant), 32'b001);
        repeat (20) applyStimulus(0, 0, 25, 1'b0);

        checkOutput("sb_grant_drain", 32'(gq.size()), 32'd0);
        checkOutput("sb_done_drain", 32'(dq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #(20 * 20000);
        $display("[TB] FAIL watchdog: simulation did not finish within cycle budget");
        $fatal(1);
    end

endmodule
